// File: rtl/atomik_status_leds.sv
// atomik_status_leds
// Multi-channel LED/status indicator engine. Each channel turns one status
// source into a board LED drive, using a mode that can be changed at runtime:
//   0 OFF, 1 LEVEL, 2 ACTIVITY (pulse stretch), 3 BLINK, 4 GATED_BLINK,
//   5 LATCH, 6/7 reserved (behave as OFF).
// Every channel has its own event synchroniser, an either-polarity edge
// detector, a stretch down-counter and a sticky latch. All channels share one
// free-running blink counter.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ev_in     raw asynchronous event lines, one per channel
//   lvl_in    level inputs, already in the clk domain
//   cfg_we    mode write strobe (one cycle)
//   cfg_ch    target channel of the write; values >= NUM_CH are ignored
//   cfg_mode  new mode for the target channel
//   led       registered LED drive; polarity set by ACTIVE_LOW
//   act_flag  registered, active-high: the channel's stretch counter is
//             non-zero, whatever the channel's mode
module atomik_status_leds #(
    parameter int                  NUM_CH        = 6,
    parameter int                  SYNC_STAGES   = 3,
    parameter logic [NUM_CH-1:0]   EV_IDLE       = {NUM_CH{1'b1}},
    parameter int                  STRETCH_CYC   = 1_048_575,
    parameter int                  BLINK_LOG2    = 23,
    parameter bit                  ACTIVE_LOW    = 1'b1,
    parameter logic [3*NUM_CH-1:0] DEFAULT_MODES = {NUM_CH{3'd1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ev_in,
    input  logic [NUM_CH-1:0] lvl_in,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [2:0]        cfg_mode,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] act_flag
);

    localparam int          BCW          = BLINK_LOG2 + 1;
    localparam logic [23:0] STRETCH_LOAD = 24'(STRETCH_CYC);

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_LEVEL  = 3'd1;
    localparam logic [2:0] MODE_ACT    = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;
    localparam logic [2:0] MODE_GBLINK = 3'd4;
    localparam logic [2:0] MODE_LATCH  = 3'd5;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d1_q;
    logic [NUM_CH-1:0] ev_edge;

    logic [23:0]       stretch_q [NUM_CH];
    logic [23:0]       stretch_d [NUM_CH];
    logic [2:0]        mode_q    [NUM_CH];
    logic [2:0]        mode_d    [NUM_CH];
    logic [NUM_CH-1:0] latch_q, latch_d;
    logic [BCW-1:0]    blink_cnt_q;
    logic              blink;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] on;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] act_q, act_d;

    // Event synchronisers. Stages start at EV_IDLE so that a line already
    // sitting at its idle level when reset is released gives no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= EV_IDLE;
            end
            sync_d1_q <= EV_IDLE;
        end else begin
            sync_q[0] <= ev_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_d1_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ev_edge = sync_q[SYNC_STAGES-1] ^ sync_d1_q;
    assign blink   = blink_cnt_q[BLINK_LOG2];

    // A write to a channel that does not exist must not touch any channel.
    always_comb begin
        cfg_hit = '0;
        if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(cfg_ch) == i) begin
                    cfg_hit[i] = 1'b1;
                end
            end
        end
    end

    // Per-channel next state. A config write takes priority over an edge in
    // the same cycle, so the edge is dropped and counter and latch read 0.
    // A retrigger reloads the counter; stretch time never accumulates.
    always_comb begin
        latch_d = latch_q;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]    = mode_q[i];
            stretch_d[i] = stretch_q[i];
            if (cfg_hit[i]) begin
                mode_d[i]    = cfg_mode;
                stretch_d[i] = '0;
                latch_d[i]   = 1'b0;
            end else if (ev_edge[i]) begin
                stretch_d[i] = STRETCH_LOAD;
                latch_d[i]   = 1'b1;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - 24'd1;
            end
        end
    end

    // Mode decode; the result is registered in led_q, so no input reaches an
    // output without passing through a flop.
    always_comb begin
        on    = '0;
        led_d = '0;
        act_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                MODE_OFF:    on[i] = 1'b0;
                MODE_LEVEL:  on[i] = lvl_in[i];
                MODE_ACT:    on[i] = (stretch_q[i] != '0);
                MODE_BLINK:  on[i] = blink;
                MODE_GBLINK: on[i] = lvl_in[i] & blink;
                MODE_LATCH:  on[i] = latch_q[i];
                default:     on[i] = 1'b0;
            endcase
            led_d[i] = on[i] ^ ACTIVE_LOW;
            act_d[i] = (stretch_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]    <= DEFAULT_MODES[3*i +: 3];
                stretch_q[i] <= '0;
            end
            latch_q     <= '0;
            blink_cnt_q <= '0;
            led_q       <= {NUM_CH{ACTIVE_LOW}};
            act_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]    <= mode_d[i];
                stretch_q[i] <= stretch_d[i];
            end
            latch_q     <= latch_d;
            blink_cnt_q <= blink_cnt_q + BCW'(1);
            led_q       <= led_d;
            act_q       <= act_d;
        end
    end

    assign led      = led_q;
    assign act_flag = act_q;

endmodule

// File: tb/tb_atomik_status_leds.sv
// Bench for atomik_status_leds. A reference model keeps, for each channel, the
// time of its last stretch load and a sticky latch bit. It derives edges from
// a history of ev_in samples and blink from the cycle count since reset.
// At every clock edge it pushes the expected {led, act_flag} into a queue. A
// separate monitor pops that queue and compares it with the DUT outputs.
module tb_atomik_status_leds;

    localparam int NCH     = 4;
    localparam int SS      = 2;
    localparam int STRETCH = 8;
    localparam int BL2     = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ev_in;
    logic [NCH-1:0] lvl_in;
    logic           cfg_we;
    logic [3:0]     cfg_ch;
    logic [2:0]     cfg_mode;
    logic [NCH-1:0] led;
    logic [NCH-1:0] act_flag;

    always #5 clk = ~clk;

    atomik_status_leds #(
        .NUM_CH        (NCH),
        .SYNC_STAGES   (SS),
        .EV_IDLE       (4'hF),
        .STRETCH_CYC   (STRETCH),
        .BLINK_LOG2    (BL2),
        .ACTIVE_LOW    (1'b1),
        .DEFAULT_MODES ({4{3'd1}})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev_in),
        .lvl_in   (lvl_in),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .led      (led),
        .act_flag (act_flag)
    );

    logic [7:0] exp_q [$];
    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int             n;
    int             m_mode [NCH];
    bit             m_latch[NCH];
    bit             m_has  [NCH];
    int             m_last [NCH];
    logic [NCH-1:0] samp_q [$];

    task automatic model_reset();
        n = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_mode[ch]  = 1;
            m_latch[ch] = 1'b0;
            m_has[ch]   = 1'b0;
            m_last[ch]  = 0;
        end
        samp_q.delete();
        for (int k = 0; k <= SS; k++) samp_q.push_back(4'hF);
    endtask

    task automatic model_step();
        logic [NCH-1:0] e_led, e_act, new_s, old_s;
        bit bl, on;
        n++;
        bl = (((n - 1) / (1 << BL2)) % 2) == 1;
        for (int ch = 0; ch < NCH; ch++) begin
            e_act[ch] = m_has[ch] && ((n - 1 - m_last[ch]) < STRETCH);
            case (m_mode[ch])
                1:       on = lvl_in[ch];
                2:       on = e_act[ch];
                3:       on = bl;
                4:       on = lvl_in[ch] && bl;
                5:       on = m_latch[ch];
                default: on = 1'b0;
            endcase
            e_led[ch] = !on;
        end
        // Edge that loads at this clock: synchronised samples taken SS and
        // SS+1 clocks ago differ.
        new_s = samp_q[samp_q.size() - SS];
        old_s = samp_q[samp_q.size() - SS - 1];
        for (int ch = 0; ch < NCH; ch++) begin
            if (cfg_we && cfg_ch < NCH && cfg_ch == ch) begin
                m_mode[ch]  = int'(cfg_mode);
                m_latch[ch] = 1'b0;
                m_has[ch]   = 1'b0;
            end else if (new_s[ch] != old_s[ch]) begin
                m_last[ch]  = n;
                m_has[ch]   = 1'b1;
                m_latch[ch] = 1'b1;
            end
        end
        samp_q.push_back(ev_in);
        if (samp_q.size() > 8) void'(samp_q.pop_front());
        exp_q.push_back({e_led, e_act});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                exp_q.push_back({4'hF, 4'h0});
            end else begin
                model_step();
            end
        end
    end

    // monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if ({led, act_flag} !== e) begin
                    miscompares++;
                    $display("FAIL led_act at %0t: led/act_flag got %b/%b expected %b/%b",
                             $time, led, act_flag, e[7:4], e[3:0]);
                end
            end
        end
    end

    task automatic cfg_write(input logic [3:0] ch, input logic [2:0] m);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = m;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // stimulus
    initial begin
        int b;
        rst_n    = 1'b0;
        ev_in    = 4'hF;
        lvl_in   = 4'hF;
        cfg_we   = 1'b0;
        cfg_ch   = 4'd0;
        cfg_mode = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        cfg_write(4'd0, 3'd3);
        cfg_write(4'd1, 3'd4);
        cfg_write(4'd2, 3'd2);
        cfg_write(4'd3, 3'd5);
        lvl_in = 4'b1101;
        repeat (4) @(negedge clk);

        // activity and retrigger
        ev_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        ev_in[2] = 1'b1;
        repeat (16) @(negedge clk);

        // latch, then clear by rewriting the mode
        ev_in[3] = 1'b0;
        @(negedge clk);
        ev_in[3] = 1'b1;
        repeat (12) @(negedge clk);
        cfg_write(4'd3, 3'd5);
        repeat (4) @(negedge clk);

        // write to ch2 on the same clock its edge would load; ch1 edge too
        ev_in[2] = 1'b0;
        ev_in[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cfg_write(4'd2, 3'd2);
        repeat (12) @(negedge clk);

        // out-of-range channel and reserved mode
        cfg_write(4'd9, 3'd0);
        repeat (4) @(negedge clk);
        cfg_write(4'd0, 3'd7);
        repeat (20) @(negedge clk);

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 1500; c++) begin
            lvl_in = 4'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                b = $urandom_range(0, 3);
                ev_in[b] = ~ev_in[b];
            end
            cfg_we = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
                cfg_mode = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                       : 3'($urandom_range(1, 5));
            end
            if (c == 700) rst_n = 1'b0;
            if (c == 703) rst_n = 1'b1;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/atomik_status_leds.md
# atomik_status_leds

Parametrised LED/status indicator engine for ATOMiK top-levels: a generalisation of the fixed per-LED heartbeat, RX-activity-stretch and level-mapping logic. It offers NUM_CH independent channels. Each channel has a runtime-selectable mode: off, level, activity pulse-stretch, blink, gated blink or sticky latch. Each channel also has its own input synchroniser and edge detector, plus configurable output polarity. It sits between core/loader status signals and the board LED pins, in the system clock domain.

## Interface
- NUM_CH, 6: number of channels (1–16).
- SYNC_STAGES, 3: flops per ev_in synchroniser (≥2).
- EV_IDLE, {NUM_CH{1'b1}}: reset value of every synchroniser stage and edge-detect flop, per channel.
- STRETCH_CYC, 1_048_575: activity stretch length in cycles (≥1, fits 24 bits).
- BLINK_LOG2, 23: blink phase = bit BLINK_LOG2 of free-running counter.
- ACTIVE_LOW, 1: 1 = led driven low when "on".
- DEFAULT_MODES, {NUM_CH{3'd1}}: packed 3-bit reset mode per channel (channel i at [3i+2:3i]).

- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ev_in  in  NUM_CH  raw asynchronous event lines (e.g. uart_rx).
- lvl_in  in  NUM_CH  synchronous level inputs (already in clk domain).
- cfg_we  in  1  mode write strobe, one cycle.
- cfg_ch  in  4  target channel.
- cfg_mode  in  3  new mode.
- led  out  NUM_CH  registered LED drive, polarity per ACTIVE_LOW.
- act_flag  out  NUM_CH  registered, active-high: channel stretch counter non-zero, independent of mode.

## Operation
- Reset: synchronisers and edge flops = EV_IDLE; stretch counters 0; latches 0; blink counter 0; modes = DEFAULT_MODES; led = all inactive ({NUM_CH{ACTIVE_LOW}}); act_flag = 0.
- Per channel: ev_in → SYNC_STAGES chain → s; edge = s ^ s_d1 (either polarity).
- Stretch counter: on edge load STRETCH_CYC; otherwise decrement if non-zero, hold at 0. Retrigger while non-zero reloads (no accumulation).
- Latch: set on edge; cleared only by cfg write to that channel.
- Blink counter: free-running, width BLINK_LOG2+1, wraps silently; blink = cnt[BLINK_LOG2].
- Mode decode (on = logical indicator before polarity):
  - 0 OFF: 0.
  - 1 LEVEL: lvl_in.
  - 2 ACTIVITY: stretch != 0.
  - 3 BLINK: blink.
  - 4 GATED_BLINK: lvl_in & blink.
  - 5 LATCH: latch.
  - 6, 7: reserved, behave as OFF.
- led[i] <= on ^ ACTIVE_LOW; act_flag[i] <= (stretch != 0).
- Config: cfg_we with cfg_ch < NUM_CH writes mode, clears that channel's latch and stretch counter. cfg_ch ≥ NUM_CH: ignored, no state change.
- Simultaneous edge and cfg write on same channel: write wins; the edge is dropped (counter and latch = 0). Other channels are unaffected.
- Reset asserted mid-stretch or mid-blink: immediate return to reset values; no partial pulse after release.

## Timing
- ev_in change sampled at edge k: s changes at edge k+SYNC_STAGES−1; counter loaded at k+SYNC_STAGES; led/act_flag "on" after edge k+SYNC_STAGES+1.
- Stretch: act_flag "on" for exactly STRETCH_CYC cycles after the last edge.
- lvl_in to led: 1 cycle (registered output).
- cfg write at edge k: mode effective at k; led reflects new mode after edge k+1.
- Blink: period 2^(BLINK_LOG2+1) cycles, 50 % duty; first "on" phase begins 2^BLINK_LOG2 cycles after reset release.
- No combinational input-to-output paths.

## Test plan
Common config: NUM_CH=4, SYNC_STAGES=2, STRETCH_CYC=8, BLINK_LOG2=3, ACTIVE_LOW=1, EV_IDLE=4'hF, DEFAULT_MODES all 1.
- Reset: hold rst_n=0 with lvl_in=4'hF -> led=4'hF, act_flag=0. Release with ev_in=4'hF steady -> no act_flag pulse.
- Activity: ch2 mode 2; drop ev_in[2] at edge k -> led[2]=0 after k+3 for 8 cycles; act_flag[2] identical. Second edge 4 cycles later -> window extends to 8 cycles after that edge.
- Blink/gated: ch0 mode 3 -> led[0] toggles every 8 cycles, first low after cycle 8. ch1 mode 4 with lvl_in[1]=0 -> led[1] stays 1.
- Latch and clear: ch3 mode 5; single ev_in[3] pulse -> led[3]=0 indefinitely. cfg_we to ch3 mode 5 -> led[3]=1 two edges later.
- Collision: cfg write to ch2 in the same cycle as its edge -> act_flag[2] never asserts; ch1 edge in that cycle still stretches 8 cycles.
- Illegal index/mode: cfg_ch=9 -> no change on any channel. cfg_mode=7 on ch0 -> led[0]=1 constant.
